sram_nxm_2w2r: RTL and testbench
================================

# sram_nxm_2w2r

Parametrised register-file SRAM with two write ports and two registered read ports; generalises the fixed 7x15 single-write array. Adds same-cycle write-to-read bypass, a defined dual-write collision rule, out-of-range address handling and a reset-triggered clear sweep with a BUSY indicator. Sits in the CPU datapath as the architectural register file feeding the operand latches.

## Interface
- DATA_W, 15: data width in bits
- ADDR_W, 3: address width
- DEPTH, 7: number of entries; 1 <= DEPTH <= 2**ADDR_W
- ZERO_REG0, 0: when 1, entry 0 reads as 0 and ignores writes
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- RA1  in  ADDR_W  read address, port 1
- RA2  in  ADDR_W  read address, port 2
- WA1  in  ADDR_W  write address, port 1
- WD1  in  DATA_W  write data, port 1
- WE1  in  1  write enable, port 1
- WA2  in  ADDR_W  write address, port 2
- WD2  in  DATA_W  write data, port 2
- WE2  in  1  write enable, port 2
- RD1  out  DATA_W  registered read data, port 1
- RD2  out  DATA_W  registered read data, port 2
- BUSY  out  1  clear sweep in progress; writes ignored, reads return 0

## Operation
- States: CLEAR, IDLE. BUSY = (state == CLEAR).
- Edge with rst=1: state<=CLEAR, sweep pointer ptr<=0, RD1<=0, RD2<=0. Memory untouched on this edge.
- CLEAR, rst=0: mem[ptr]<=0, ptr<=ptr+1; on the edge where ptr==DEPTH-1, state<=IDLE. WE1/WE2 ignored; RD1/RD2 <=0.
- rst re-asserted mid-sweep: ptr restarts at 0; sweep runs the full DEPTH cycles again.
- IDLE writes: mem[WAn]<=WDn when WEn=1 and WAn<DEPTH. Out-of-range write is dropped, no side effect.
- Collision: WE1=WE2=1 and WA1==WA2 -> port 1 data stored, port 2 dropped.
- ZERO_REG0=1: writes to address 0 dropped; reads of address 0 return 0, including bypass.
- IDLE reads: RDn<=value of entry RAn at the edge. RAn>=DEPTH -> 0.
- Bypass: if RAn matches an enabled, in-range, accepted write in the same cycle, RDn<=that WD (port 1 priority on collision), not the stale entry.
- Both read ports independent; RA1==RA2 legal, both return same data.

## Timing
- Read latency 1 cycle: RAn presented before edge k -> RDn valid after edge k, held until next edge.
- Write visible in storage after the edge; visible on RD after the same edge via bypass.
- Reset: RD1=RD2=0, BUSY=1 after reset edge; BUSY falls after exactly DEPTH rst=0 edges (7 by default).
- First accepted write: first edge with BUSY=0 sampled before it.
- No combinational path from inputs to outputs.

## Test plan
- Reset sweep: preload all entries 15'h7FFF, pulse rst one cycle -> BUSY=1 for 7 edges, then 0; reading 0..6 returns 0; writes during BUSY leave entries 0.
- Basic dual write: WA1=0 WD1=15'h0018, WA2=5 WD2=15'h0005, both WE -> next cycle RA1=0,RA2=5 gives RD1=15'h0018, RD2=15'h0005.
- Collision: WA1=WA2=6, WD1=15'h0007, WD2=15'h0123 -> entry 6 = 15'h0007; same-cycle RA1=6 bypasses RD1=15'h0007.
- Bypass vs stale: entry 3 = 15'h0AAA, write 15'h0555 to 3 with RA2=3 same cycle -> RD2=15'h0555 after that edge.
- Out-of-range: write 15'h7FFF to address 7 (DEPTH=7) -> RA1=7 returns 0, entries 0..6 unchanged.
- Reset mid-sweep and ZERO_REG0=1: rst at sweep cycle 3 -> BUSY stays high 7 more edges; with ZERO_REG0=1 write 15'h0011 to 0 -> RD1=0.

Source files
------------

// File: rtl/sram_nxm_2w2r.sv
// sram_nxm_2w2r
//   Parametrised register-file SRAM that serves as the architectural register
//   file. It has two write ports and two registered read ports. Same-cycle
//   writes are bypassed to the read ports. On a dual-write collision, port 1
//   wins. Out-of-range writes are dropped and out-of-range reads return 0.
//   After every reset a clear sweep zeroes the whole array, and BUSY is high
//   while the sweep runs.
//
// Ports
//   clk_i            clock; all state changes on the rising edge
//   rst_i            synchronous active-high reset
//   ra1_i, ra2_i     read addresses
//   wa1_i/wd1_i/we1_i  write port 1 (address, data, enable)
//   wa2_i/wd2_i/we2_i  write port 2 (address, data, enable)
//   rd1_o, rd2_o     registered read data (1-cycle latency)
//   busy_o           clear sweep in progress; writes ignored, reads return 0
//
// States
//   ST_CLEAR | sweeping mem[ptr] <= 0, one entry per edge; busy_o = 1
//   ST_IDLE  | normal read/write operation
module sram_nxm_2w2r #(
    parameter int DATA_W    = 15,
    parameter int ADDR_W    = 3,
    parameter int DEPTH     = 7,
    parameter bit ZERO_REG0 = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] ra1_i,
    input  logic [ADDR_W-1:0] ra2_i,
    input  logic [ADDR_W-1:0] wa1_i,
    input  logic [DATA_W-1:0] wd1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] wa2_i,
    input  logic [DATA_W-1:0] wd2_i,
    input  logic              we2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    output logic              busy_o
);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

    // One extra bit so that DEPTH == 2**ADDR_W compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic acc1, acc2;
    logic wa1_ok, wa2_ok, ra1_ok, ra2_ok;

    // An address is usable when it is inside the array and is not the
    // hard-wired zero entry.
    assign wa1_ok = ({1'b0, wa1_i} < DEPTH_L) && !(ZERO_REG0 && (wa1_i == '0));
    assign wa2_ok = ({1'b0, wa2_i} < DEPTH_L) && !(ZERO_REG0 && (wa2_i == '0));
    assign ra1_ok = ({1'b0, ra1_i} < DEPTH_L) && !(ZERO_REG0 && (ra1_i == '0));
    assign ra2_ok = ({1'b0, ra2_i} < DEPTH_L) && !(ZERO_REG0 && (ra2_i == '0));

    // Port 2 is dropped when port 1 writes the same entry in the same cycle.
    assign acc1 = (state_q == ST_IDLE) && we1_i && wa1_ok;
    assign acc2 = (state_q == ST_IDLE) && we2_i && wa2_ok &&
                  !(acc1 && (wa1_i == wa2_i));

    assign busy_o = (state_q == ST_CLEAR);
    assign rd1_o  = rd1_q;
    assign rd2_o  = rd2_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data: an accepted same-cycle write takes precedence over the
    // stored entry, and port 1 has priority over port 2.
    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if (state_q == ST_IDLE) begin
            if (ra1_ok) begin
                if (acc1 && (wa1_i == ra1_i))      rd1_d = wd1_i;
                else if (acc2 && (wa2_i == ra1_i)) rd1_d = wd2_i;
                else                               rd1_d = mem_q[ra1_i];
            end
            if (ra2_ok) begin
                if (acc1 && (wa1_i == ra2_i))      rd2_d = wd1_i;
                else if (acc2 && (wa2_i == ra2_i)) rd2_d = wd2_i;
                else                               rd2_d = mem_q[ra2_i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
        end
    end

    // Storage is deliberately left alone on the reset edge itself.
    // The sweep that follows reset clears it.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == ST_CLEAR) begin
                mem_q[ptr_q] <= '0;
            end else begin
                if (acc1) mem_q[wa1_i] <= wd1_i;
                if (acc2) mem_q[wa2_i] <= wd2_i;
            end
        end
    end

endmodule

// File: tb/tb_sram_nxm_2w2r.sv
module tb_sram_nxm_2w2r;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ra1, ra2, wa1, wa2;
    logic [14:0] wd1, wd2;
    logic        we1, we2;
    logic [14:0] rd1, rd2, rdz1, rdz2;
    logic        busy, busyz;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        bit          chk_rd;
        logic [14:0] e1;
        logic [14:0] e2;
        logic [14:0] ez1;
        bit          chk_busy;
        logic        eb;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    sram_nxm_2w2r u_dut (
        .clk_i(clk), .rst_i(rst),
        .ra1_i(ra1), .ra2_i(ra2),
        .wa1_i(wa1), .wd1_i(wd1), .we1_i(we1),
        .wa2_i(wa2), .wd2_i(wd2), .we2_i(we2),
        .rd1_o(rd1), .rd2_o(rd2), .busy_o(busy)
    );

    sram_nxm_2w2r #(.ZERO_REG0(1'b1)) u_dutz (
        .clk_i(clk), .rst_i(rst),
        .ra1_i(ra1), .ra2_i(ra2),
        .wa1_i(wa1), .wd1_i(wd1), .we1_i(we1),
        .wa2_i(wa2), .wd2_i(wd2), .we2_i(we2),
        .rd1_o(rdz1), .rd2_o(rdz2), .busy_o(busyz)
    );

    task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Push the expectation for the inputs currently driven, clock one edge,
    // then pop and compare against what the DUT registered.
    task automatic step(input string tag, input bit chk_rd,
                        input logic [14:0] e1, input logic [14:0] e2,
                        input logic [14:0] ez1,
                        input bit chk_busy, input logic eb);
        exp_t e;
        e.tag = tag; e.chk_rd = chk_rd; e.e1 = e1; e.e2 = e2; e.ez1 = ez1;
        e.chk_busy = chk_busy; e.eb = eb;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard_empty observed=0 expected=1", tag);
        end else begin
            e = sb.pop_front();
            if (e.chk_rd) begin
                chk({e.tag, "_rd1"},  rd1,  e.e1);
                chk({e.tag, "_rd2"},  rd2,  e.e2);
                chk({e.tag, "_zrd1"}, rdz1, e.ez1);
            end
            if (e.chk_busy) begin
                chk({e.tag, "_busy"},  {14'd0, busy},  {14'd0, e.eb});
                chk({e.tag, "_zbusy"}, {14'd0, busyz}, {14'd0, e.eb});
            end
        end
    endtask

    task automatic wr_off();
        we1 = 1'b0; we2 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ra1 = '0; ra2 = '0; wa1 = '0; wa2 = '0;
        wd1 = '0; wd2 = '0; we1 = 1'b0; we2 = 1'b0;

        // Power-up reset and first sweep.
        step("reset", 1, 15'h0, 15'h0, 15'h0, 1, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 7; i++)
            step("sweep0", 1, 15'h0, 15'h0, 15'h0, 1, (i < 6));

        // Preload every entry with 7FFF; reading the same address shows bypass.
        we1 = 1'b1; we2 = 1'b1; wd1 = 15'h7FFF; wd2 = 15'h7FFF;
        for (int a = 0; a < 7; a += 2) begin
            wa1 = 3'(a); wa2 = (a == 6) ? 3'd6 : 3'(a + 1);
            ra1 = wa1;   ra2 = wa2;
            step("preload", 1, 15'h7FFF, 15'h7FFF, (a == 0) ? 15'h0 : 15'h7FFF, 0, 1'b0);
        end
        wr_off();
        for (int a = 0; a < 7; a += 2) begin
            ra1 = 3'(a); ra2 = (a == 6) ? 3'd6 : 3'(a + 1);
            step("preload_rd", 1, 15'h7FFF, 15'h7FFF, (a == 0) ? 15'h0 : 15'h7FFF, 0, 1'b0);
        end

        // Single-cycle reset pulse, then a sweep with writes to already-cleared entries.
        rst = 1'b1;
        step("rst_pulse", 1, 15'h0, 15'h0, 15'h0, 1, 1'b1);
        rst = 1'b0;
        ra1 = 3'd0; ra2 = 3'd1;
        for (int i = 0; i < 7; i++) begin
            if (i >= 5) begin
                we1 = 1'b1; wa1 = 3'd0; wd1 = 15'h7FFF;
                we2 = 1'b1; wa2 = 3'd1; wd2 = 15'h7FFF;
            end
            step("sweep1", 1, 15'h0, 15'h0, 15'h0, 1, (i < 6));
        end
        wr_off();
        for (int a = 0; a < 7; a += 2) begin
            ra1 = 3'(a); ra2 = (a == 6) ? 3'd6 : 3'(a + 1);
            step("cleared", 1, 15'h0, 15'h0, 15'h0, 0, 1'b0);
        end

        // Basic dual write.
        we1 = 1'b1; wa1 = 3'd0; wd1 = 15'h0018;
        we2 = 1'b1; wa2 = 3'd5; wd2 = 15'h0005;
        ra1 = 3'd2; ra2 = 3'd2;
        step("dual_wr", 1, 15'h0, 15'h0, 15'h0, 0, 1'b0);
        wr_off();
        ra1 = 3'd0; ra2 = 3'd5;
        step("dual_rd", 1, 15'h0018, 15'h0005, 15'h0, 0, 1'b0);

        // Collision: port 1 wins, both in storage and on the bypass.
        we1 = 1'b1; wa1 = 3'd6; wd1 = 15'h0007;
        we2 = 1'b1; wa2 = 3'd6; wd2 = 15'h0123;
        ra1 = 3'd6; ra2 = 3'd6;
        step("coll_byp", 1, 15'h0007, 15'h0007, 15'h0007, 0, 1'b0);
        wr_off();
        step("coll_rd", 1, 15'h0007, 15'h0007, 15'h0007, 0, 1'b0);

        // Bypass vs stale entry.
        we1 = 1'b1; wa1 = 3'd3; wd1 = 15'h0AAA;
        ra1 = 3'd0; ra2 = 3'd0;
        step("stale_wr", 1, 15'h0018, 15'h0018, 15'h0, 0, 1'b0);
        wr_off();
        ra1 = 3'd3; ra2 = 3'd3;
        step("stale_rd", 1, 15'h0AAA, 15'h0AAA, 15'h0AAA, 0, 1'b0);
        we2 = 1'b1; wa2 = 3'd3; wd2 = 15'h0555;
        ra1 = 3'd5; ra2 = 3'd3;
        step("byp_p2", 1, 15'h0005, 15'h0555, 15'h0005, 0, 1'b0);
        wr_off();
        ra1 = 3'd3; ra2 = 3'd3;
        step("byp_rd", 1, 15'h0555, 15'h0555, 15'h0555, 0, 1'b0);

        // Out-of-range writes and reads.
        we1 = 1'b1; wa1 = 3'd7; wd1 = 15'h7FFF;
        we2 = 1'b1; wa2 = 3'd7; wd2 = 15'h1234;
        ra1 = 3'd7; ra2 = 3'd0;
        step("oor_wr", 1, 15'h0, 15'h0018, 15'h0, 0, 1'b0);
        wr_off();
        ra1 = 3'd0; ra2 = 3'd1;
        step("oor_01", 1, 15'h0018, 15'h0, 15'h0, 0, 1'b0);
        ra1 = 3'd2; ra2 = 3'd3;
        step("oor_23", 1, 15'h0, 15'h0555, 15'h0, 0, 1'b0);
        ra1 = 3'd4; ra2 = 3'd5;
        step("oor_45", 1, 15'h0, 15'h0005, 15'h0, 0, 1'b0);
        ra1 = 3'd6; ra2 = 3'd7;
        step("oor_67", 1, 15'h0007, 15'h0, 15'h0007, 0, 1'b0);

        // Entry 0: normal instance stores it, zero-register instance drops it.
        we1 = 1'b1; wa1 = 3'd0; wd1 = 15'h0011;
        ra1 = 3'd0; ra2 = 3'd0;
        step("zero_byp", 1, 15'h0011, 15'h0011, 15'h0, 0, 1'b0);
        wr_off();
        step("zero_rd", 1, 15'h0011, 15'h0011, 15'h0, 0, 1'b0);

        // Reset re-asserted at sweep cycle 3 restarts the full sweep.
        rst = 1'b1;
        step("mid_rst0", 1, 15'h0, 15'h0, 15'h0, 1, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            step("mid_pre", 0, 15'h0, 15'h0, 15'h0, 1, 1'b1);
        rst = 1'b1;
        step("mid_rst1", 1, 15'h0, 15'h0, 15'h0, 1, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 7; i++)
            step("mid_sweep", 0, 15'h0, 15'h0, 15'h0, 1, (i < 6));
        ra1 = 3'd6; ra2 = 3'd0;
        step("mid_rd", 1, 15'h0, 15'h0, 15'h0, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
